// File: rtl/fir_coef_loader.sv
// Serialises one parallel FIR coefficient set into the filter's coefficient scan chain.
// Latency: done pulses L+1 cycles after accept (2L+1 when readback verify is built in).
// Backpressure: coef_ready is high only in IDLE; coef_valid is ignored while a pass is running.
//
// Ports:
//   ph1        clock; all state updates on its rising edge
//   resetb     synchronous reset, active-low
//   coef_valid / coef_ready   handshake for one coefficient set on coefs
//   coefs      NTAPS*CW bits, tap k = coefs[k*CW +: CW]
//   shiftIn    serial bit into the chain head (MSB of coefs first)
//   shiftClkEn chain advances one bit on every cycle this is high
//   busy       a load or verify pass is in progress
//   done       one-cycle pulse once the set is fully in the chain
//   shiftOut   chain tail bit          (only with FIR_COEF_LOADER_VERIFY_EN)
//   chk_err    sticky readback mismatch (only with FIR_COEF_LOADER_VERIFY_EN)
//
// Build option: define FIR_COEF_LOADER_VERIFY_EN to add a second pass that re-shifts
// the same word while comparing the chain tail against it.
module fir_coef_loader #(
    parameter int NTAPS = 4,
    parameter int CW    = 8
) (
    input  logic                  ph1,
    input  logic                  resetb,
    input  logic                  coef_valid,
    output logic                  coef_ready,
    input  logic [NTAPS*CW-1:0]   coefs,
    output logic                  shiftIn,
    output logic                  shiftClkEn,
    output logic                  busy,
    output logic                  done
`ifdef FIR_COEF_LOADER_VERIFY_EN
    ,
    input  logic                  shiftOut,
    output logic                  chk_err
`endif
);

    localparam int L    = NTAPS * CW;
    localparam int CNTW = $clog2(L) + 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(L - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [L-1:0]    rot_q, rot_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            sin_q, sin_d;
    logic            sen_q, sen_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef FIR_COEF_LOADER_VERIFY_EN
    logic            chk_q, chk_d;
`endif

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        sin_d   = 1'b0;
        sen_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef FIR_COEF_LOADER_VERIFY_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (coef_valid && ready_q) begin
                    rot_d   = coefs;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                    ready_d = 1'b0;
                    // Outputs are registered, so the first bit is presented straight
                    // from the incoming word rather than from the rotate register.
                    sin_d   = coefs[L-1];
                    sen_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef FIR_COEF_LOADER_VERIFY_EN
                    chk_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                // Rotating (not shifting) leaves the original word in rot_q after L
                // cycles, which the verify pass relies on.
                rot_d  = {rot_q[L-2:0], rot_q[L-1]};
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                sen_d  = 1'b1;
                sin_d  = rot_q[L-2];
                if (cnt_q == LAST) begin
`ifdef FIR_COEF_LOADER_VERIFY_EN
                    state_d = ST_VERIFY;
                    cnt_d   = '0;
`else
                    state_d = ST_DONE;
                    sen_d   = 1'b0;
                    sin_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef FIR_COEF_LOADER_VERIFY_EN
            ST_VERIFY: begin
                rot_d  = {rot_q[L-2:0], rot_q[L-1]};
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                sen_d  = 1'b1;
                sin_d  = rot_q[L-2];
                // The chain tail should replay the word in the same order it went in.
                if (shiftOut != rot_q[L-1]) begin
                    chk_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    sen_d   = 1'b0;
                    sin_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            rot_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            sin_q   <= 1'b0;
            sen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIR_COEF_LOADER_VERIFY_EN
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sin_q   <= sin_d;
            sen_q   <= sen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIR_COEF_LOADER_VERIFY_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign coef_ready = ready_q;
    assign shiftIn    = sin_q;
    assign shiftClkEn = sen_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef FIR_COEF_LOADER_VERIFY_EN
    assign chk_err    = chk_q;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: scoreboard of expected serial bits and done events.
// Stimulus drives 1ns after the rising edge; the monitor samples on the falling edge.
// A behavioural 32-bit scan chain stands in for the filter's coefficient registers.
module tb_fir_coef_loader;

    localparam int L = 32;
`ifdef FIR_COEF_LOADER_VERIFY_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] word;
        logic        chk;
    } done_rec_t;

    logic        ph1 = 1'b0;
    logic        resetb = 1'b0;
    logic        coef_valid = 1'b0;
    logic        coef_ready;
    logic [31:0] coefs = '0;
    logic        shiftIn;
    logic        shiftClkEn;
    logic        busy;
    logic        done;
`ifdef FIR_COEF_LOADER_VERIFY_EN
    logic        shiftOut;
    logic        chk_err;
    logic        force_so = 1'b0;
`endif

    logic [31:0] chain = '0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          shift_cnt = 0;
    int          overlap = 0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_chk = 1'b0;
    logic        exp_bits[$];
    done_rec_t   exp_done[$];

    always #5 ph1 = ~ph1;

    fir_coef_loader dut (
        .ph1        (ph1),
        .resetb     (resetb),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coefs      (coefs),
        .shiftIn    (shiftIn),
        .shiftClkEn (shiftClkEn),
        .busy       (busy),
        .done       (done)
`ifdef FIR_COEF_LOADER_VERIFY_EN
        ,
        .shiftOut   (shiftOut),
        .chk_err    (chk_err)
`endif
    );

`ifdef FIR_COEF_LOADER_VERIFY_EN
    assign shiftOut = force_so ? 1'b0 : chain[31];
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural coefficient chain: head at bit 0, tail at bit 31.
    always @(posedge ph1) begin
        if (shiftClkEn === 1'b1) chain <= {chain[30:0], shiftIn};
    end

    // Edge counter and handshake observer: each accepted set queues its serial stream
    // (MSB first, once per pass) and the expected done event.
    always @(posedge ph1) begin
        done_rec_t r;
        cyc <= cyc + 1;
        if (resetb === 1'b1 && coef_valid === 1'b1 && coef_ready === 1'b1) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc + 1;
            for (int p = 0; p < NPASS; p++)
                for (int k = 0; k < L; k++) exp_bits.push_back(coefs[L-1-k]);
            r.cyc  = cyc + 1 + NPASS * L;
            r.word = coefs;
            r.chk  = exp_chk;
            exp_done.push_back(r);
        end
    end

    // Monitor
    always @(negedge ph1) begin
        done_rec_t r;
        logic      b;
        if (shiftClkEn === 1'b1) begin
            shift_cnt++;
            if (coef_ready === 1'b1) overlap++;
            if (exp_bits.size() == 0) begin
                chk("unexpected_shift", 1'b1, 1'b0);
            end else begin
                b = exp_bits.pop_front();
                chk("shiftIn_bit", shiftIn, b);
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                r = exp_done.pop_front();
                chk("done_cycle", cyc, r.cyc);
                chk("shift_cycles", shift_cnt, NPASS * L);
                chk("chain_contents", chain, r.word);
`ifdef FIR_COEF_LOADER_VERIFY_EN
                chk("chk_err_at_done", chk_err, r.chk);
`endif
            end
            shift_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        int n0;
        n0 = acc_cnt;
        coefs = w;
        coef_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_cnt != n0) break;
        end
        chk("accept_seen", acc_cnt != n0, 1'b1);
        coef_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (exp_done.size() == 0) break;
            tick();
        end
        chk("done_timeout_pending", exp_done.size(), 0);
        exp_done.delete();
        exp_bits.delete();
        tick();
    endtask

    initial begin
        int a1;
        int y;
        // 1. Reset and idle
        repeat (2) @(posedge ph1);
        @(negedge ph1);
        chk("rst_coef_ready", coef_ready, 1'b1);
        chk("rst_shiftClkEn", shiftClkEn, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_shiftIn", shiftIn, 1'b0);
        tick();
        resetb = 1'b1;
        shift_cnt = 0;
        repeat (10) tick();
        chk("idle_no_shift", shift_cnt, 0);
        chk("idle_ready", coef_ready, 1'b1);

        // 2. Basic load; taps 1,2,3,4 and y = 1*10 + 2*20 + 3*30 + 4*40 = 300
        load(32'h04_03_02_01);
        wait_done();
        chk("tap_c0", chain[7:0], 8'd1);
        chk("tap_c1", chain[15:8], 8'd2);
        chk("tap_c2", chain[23:16], 8'd3);
        chk("tap_c3", chain[31:24], 8'd4);
        y = chain[7:0] * 10 + chain[15:8] * 20 + chain[23:16] * 30 + chain[31:24] * 40;
        chk("fir_y", y, 300);

        // 3. coef_valid held high, set changed mid-load
        coefs = 32'h11223344;
        coef_valid = 1'b1;
        a1 = acc_cnt;
        for (int i = 0; i < 200 && acc_cnt == a1; i++) tick();
        a1 = acc_cyc;
        repeat (5) tick();
        coefs = 32'hCAFEBABE;
        for (int i = 0; i < 200 && acc_cnt < 3; i++) tick();
        chk("second_accept_seen", acc_cnt, 3);
        chk("accept_spacing", acc_cyc - a1, NPASS * L + 2);
        coef_valid = 1'b0;
        wait_done();

        // 4. Reset during a load, then reload
        load(32'h12345678);
        repeat (9) tick();
        resetb = 1'b0;
        tick();
        exp_bits.delete();
        exp_done.delete();
        shift_cnt = 0;
        @(negedge ph1);
        chk("abort_shiftClkEn", shiftClkEn, 1'b0);
        chk("abort_coef_ready", coef_ready, 1'b1);
        chk("abort_done", done, 1'b0);
        tick();
        resetb = 1'b1;
        repeat (40) tick();
        load(32'hFF_00_FF_00);
        wait_done();
        chk("reload_c0", chain[7:0], 8'h00);
        chk("reload_c3", chain[31:24], 8'hFF);

`ifdef FIR_COEF_LOADER_VERIFY_EN
        // 5. Readback verify: healthy, stuck-at-0 tail, then cleared by next accept
        exp_chk = 1'b0;
        load(32'hA5_5A_C3_3C);
        wait_done();
        force_so = 1'b1;
        exp_chk = 1'b1;
        load(32'hA5_5A_C3_3C);
        wait_done();
        force_so = 1'b0;
        exp_chk = 1'b0;
        load(32'h0F0F0F0F);
        chk("chk_err_cleared_on_accept", chk_err, 1'b0);
        wait_done();
`endif

        // 6. All ones then all zeros
        load(32'hFFFFFFFF);
        wait_done();
        load(32'h00000000);
        wait_done();

        chk("no_shift_while_ready", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

endmodule
